// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display driver: active-low glyphs
// ({g,f,e,d,c,b,a}, 0 = segment lit) and the scroll FSM state encoding.
package seven_seg_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'b0011000;
  localparam logic [SEG_W-1:0] SEG_HEX_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_HEX_B = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_HEX_C = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_HEX_D = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_HEX_E = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_HEX_F = 7'b0001110;

  typedef enum logic [1:0] {
    ST_STATIC      = 2'd0,
    ST_SCROLL      = 2'd1,
    ST_SCROLL_STEP = 2'd2
  } disp_state_e;

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
//  hex    in  4  nibble to display
//  seg_c  out 7  {g,f,e,d,c,b,a}, 0 = segment lit
module hex_to_seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    unique case (hex)
      4'h0: seg_c = SEG_HEX_0;
      4'h1: seg_c = SEG_HEX_1;
      4'h2: seg_c = SEG_HEX_2;
      4'h3: seg_c = SEG_HEX_3;
      4'h4: seg_c = SEG_HEX_4;
      4'h5: seg_c = SEG_HEX_5;
      4'h6: seg_c = SEG_HEX_6;
      4'h7: seg_c = SEG_HEX_7;
      4'h8: seg_c = SEG_HEX_8;
      4'h9: seg_c = SEG_HEX_9;
      4'hA: seg_c = SEG_HEX_A;
      4'hB: seg_c = SEG_HEX_B;
      4'hC: seg_c = SEG_HEX_C;
      4'hD: seg_c = SEG_HEX_D;
      4'hE: seg_c = SEG_HEX_E;
      4'hF: seg_c = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_display_ctrl.sv
// Registered driver for NUM_DIGITS active-low seven-segment digits with
// leading-zero blanking, per-digit blank/blink masks and a scroll mode.
//  clk, rst_n   clock, asynchronous active-low reset
//  load_valid   new digit data offered; load_ready: data accepted this cycle
//  load_data    nibble per digit, digit i at [4i+3:4i]
//  blank_mask   per-digit force blank (live)
//  blink_mask   per-digit blink enable (live)
//  lz_en        blank leading zeros
//  scroll_en    1 = scroll mode, 0 = static
//  segs         registered segments, digit i at [7i+6:7i], 0 = lit
module seven_seg_display_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned BLINK_DIV  = 25_000_000,
  parameter int unsigned SCROLL_DIV = 12_500_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [4*NUM_DIGITS-1:0]     load_data,
  input  logic [NUM_DIGITS-1:0]       blank_mask,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
  input  logic                        lz_en,
  input  logic                        scroll_en,
  output logic [SEG_W*NUM_DIGITS-1:0] segs
);

  localparam int unsigned DATA_W   = 4 * NUM_DIGITS;
  localparam int unsigned SEGS_W   = SEG_W * NUM_DIGITS;
  localparam int unsigned RING_LEN = NUM_DIGITS + 1;
  localparam int unsigned BLINK_W  = $clog2(BLINK_DIV);
  localparam int unsigned SCROLL_W = $clog2(SCROLL_DIV);
  localparam int unsigned OFS_W    = $clog2(RING_LEN);
  localparam int unsigned POS_W    = OFS_W + 1;

  localparam logic [BLINK_W-1:0]  BLINK_LAST  = BLINK_W'(BLINK_DIV - 1);
  localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_DIV - 1);
  localparam logic [OFS_W-1:0]    OFS_LAST    = OFS_W'(NUM_DIGITS);
  localparam logic [POS_W-1:0]    POS_WRAP    = POS_W'(RING_LEN);

  logic [DATA_W-1:0]   data_q;
  logic [BLINK_W-1:0]  blink_cnt_q;
  logic                blink_on_q;
  disp_state_e         state_q, state_d;
  logic [SCROLL_W-1:0] scroll_cnt_q, scroll_cnt_d;
  logic [OFS_W-1:0]    offset_q, offset_d;
  logic [SEGS_W-1:0]   segs_d;

  logic [SEG_W-1:0]      glyph [NUM_DIGITS];
  logic [SEG_W-1:0]      ring  [RING_LEN];
  logic [NUM_DIGITS-1:0] lz_blank;
  logic [POS_W-1:0]      pos;

  // Hold register for the accepted digit nibbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load_valid && load_ready) begin
      data_q <= load_data;
    end
  end

  // Free-running blink timebase; phase flips on every wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q <= '0;
      blink_on_q  <= ~blink_on_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
    end
  end

  // Scroll FSM state register; load_ready is registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_STATIC;
      scroll_cnt_q <= '0;
      offset_q     <= '0;
      load_ready   <= 1'b1;
    end else begin
      state_q      <= state_d;
      scroll_cnt_q <= scroll_cnt_d;
      offset_q     <= offset_d;
      load_ready   <= (state_d != ST_SCROLL_STEP);
    end
  end

  // Scroll FSM next state; dropping scroll_en overrides any pending step
  always_comb begin
    state_d      = state_q;
    scroll_cnt_d = scroll_cnt_q;
    offset_d     = offset_q;
    if (!scroll_en) begin
      state_d      = ST_STATIC;
      scroll_cnt_d = '0;
      offset_d     = '0;
    end else begin
      unique case (state_q)
        ST_STATIC: begin
          state_d      = ST_SCROLL;
          scroll_cnt_d = '0;
        end
        ST_SCROLL: begin
          if (scroll_cnt_q == SCROLL_LAST) begin
            scroll_cnt_d = '0;
            state_d      = ST_SCROLL_STEP;
          end else begin
            scroll_cnt_d = scroll_cnt_q + SCROLL_W'(1);
          end
        end
        ST_SCROLL_STEP: begin
          state_d  = ST_SCROLL;
          offset_d = (offset_q == OFS_LAST) ? '0 : offset_q + OFS_W'(1);
        end
        default: state_d = ST_STATIC;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    hex_to_seven_seg u_dec (
      .hex   (data_q[4*i +: 4]),
      .seg_c (glyph[i])
    );
  end

  // Leading-zero blanking on unrotated data; digit 0 always stays visible
  always_comb begin
    logic upper_zero;
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero  = upper_zero && (data_q[4*i +: 4] == 4'h0);
      lz_blank[i] = lz_en && upper_zero;
    end
  end

  // Ring of digit glyphs followed by one blank separator position
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      ring[i] = lz_blank[i] ? SEG_BLANK : glyph[i];
    end
    ring[NUM_DIGITS] = SEG_BLANK;
  end

  // Per displayed position: rotate by offset, then apply masks on top
  always_comb begin
    segs_d = '1;
    pos    = '0;
    for (int p = 0; p < NUM_DIGITS; p++) begin
      pos = POS_W'(p) + POS_W'(offset_q);
      if (pos >= POS_WRAP) pos = pos - POS_WRAP;
      if (blank_mask[p]) begin
        segs_d[SEG_W*p +: SEG_W] = SEG_BLANK;
      end else if (blink_mask[p] && !blink_on_q) begin
        segs_d[SEG_W*p +: SEG_W] = SEG_BLANK;
      end else begin
        segs_d[SEG_W*p +: SEG_W] = ring[pos[OFS_W-1:0]];
      end
    end
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segs <= '1;
    end else begin
      segs <= segs_d;
    end
  end

endmodule
